// File: rtl/path_delay_meter.sv
// rtl/path_delay_meter.sv - launch/capture delay-path tester with optional worst-case arrival latency
// Optional latency measurement is enabled by defining PDM_LATENCY_EN.
module path_delay_meter #(
  parameter int TRIAL_W = 8,
  parameter int DLY_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [TRIAL_W-1:0] num_trials,
  input  logic [DLY_W-1:0]   capture_delay,
  output logic               path_input,
  input  logic               path_result,
  output logic               busy,
  output logic               done,
  output logic [TRIAL_W-1:0] fail_count,
  output logic [DLY_W-1:0]   max_latency
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [TRIAL_W-1:0] TRIAL_ONE = TRIAL_W'(1);
  localparam logic [DLY_W-1:0]   DLY_ONE   = DLY_W'(1);

  state_t             state, state_nxt;
  logic [TRIAL_W-1:0] trials_q;
  logic [TRIAL_W-1:0] trial_cnt;
  logic [DLY_W-1:0]   delay_q;
  logic [DLY_W-1:0]   wait_cnt;
  logic               res_q;
  logic               accept;
  logic               last_trial;
  logic               launch_go;

  assign accept     = (state == S_IDLE) && start;
  assign last_trial = ((trial_cnt + TRIAL_ONE) == trials_q);
  // path_input flips on entry to LAUNCH so the new level is already on the path during LAUNCH
  assign launch_go  = (accept && (num_trials != '0)) ||
                      ((state == S_CAPTURE) && !last_trial);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_LAUNCH;
      S_LAUNCH:  state_nxt = (trials_q == '0) ? S_DONE : S_WAIT;
      S_WAIT:    if (wait_cnt <= DLY_ONE) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = last_trial ? S_DONE : S_LAUNCH;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      path_input <= 1'b0;
      res_q      <= 1'b0;
      trials_q   <= '0;
      trial_cnt  <= '0;
      delay_q    <= '0;
      wait_cnt   <= '0;
      fail_count <= '0;
    end else begin
      res_q <= path_result;
      if (launch_go) begin
        path_input <= ~path_input;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            trials_q   <= num_trials;
            delay_q    <= (capture_delay == '0) ? DLY_ONE : capture_delay;
            trial_cnt  <= '0;
            fail_count <= '0;
          end
        end
        S_LAUNCH: wait_cnt <= delay_q;
        S_WAIT:   wait_cnt <= wait_cnt - DLY_ONE;
        S_CAPTURE: begin
          trial_cnt <= trial_cnt + TRIAL_ONE;
          if ((res_q != path_input) && (fail_count != '1)) begin
            fail_count <= fail_count + TRIAL_ONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PDM_LATENCY_EN
  logic [DLY_W-1:0] lat_cnt;
  logic [DLY_W-1:0] max_lat_q;
  logic [DLY_W-1:0] miss_lat;
  logic             arrived;

  // a trial that never arrives is charged one cycle beyond its capture window
  assign miss_lat    = (&delay_q) ? delay_q : (delay_q + DLY_ONE);
  assign max_latency = max_lat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt   <= '0;
      max_lat_q <= '0;
      arrived   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            max_lat_q <= '0;
          end
        end
        S_LAUNCH: begin
          lat_cnt <= DLY_ONE;
          arrived <= 1'b0;
        end
        S_WAIT: begin
          if (lat_cnt != '1) begin
            lat_cnt <= lat_cnt + DLY_ONE;
          end
          if (!arrived && (res_q == path_input)) begin
            arrived <= 1'b1;
            if (lat_cnt > max_lat_q) begin
              max_lat_q <= lat_cnt;
            end
          end
        end
        S_CAPTURE: begin
          if (!arrived && (miss_lat > max_lat_q)) begin
            max_lat_q <= miss_lat;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign max_latency = '0;
`endif

endmodule

// File: tb/tb_path_delay_meter.sv
// tb/tb_path_delay_meter.sv - directed self-checking bench for path_delay_meter
module tb_path_delay_meter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] num_trials;
  logic [3:0] capture_delay;
  logic       path_input;
  logic       path_result;
  logic       busy;
  logic       done;
  logic [7:0] fail_count;
  logic [3:0] max_latency;

  int checks = 0;
  int failures = 0;
  int k = 1;
  logic [7:0] sr = '0;

`ifdef PDM_LATENCY_EN
  localparam bit LAT_EN = 1'b1;
`else
  localparam bit LAT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  // delay path under test: k-cycle shift register
  always @(posedge clk) sr <= {sr[6:0], path_input};
  assign path_result = sr[k-1];

  path_delay_meter #(.TRIAL_W(8), .DLY_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .num_trials(num_trials),
    .capture_delay(capture_delay), .path_input(path_input),
    .path_result(path_result), .busy(busy), .done(done),
    .fail_count(fail_count), .max_latency(max_latency)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // cycles are counted from LAUNCH entry (the cycle after start) to the DONE cycle
  task automatic run_meas(input string tag, input int kk, input int n, input int cd,
                          input int exp_fail, input int exp_cyc, input int exp_pi,
                          input int exp_lat, input bit disturb);
    int cyc;
    k = kk;
    idle(10);
    num_trials = 8'(n);
    capture_delay = 4'(cd);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_run"}, 32'(busy), 32'd1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 1000) begin
      if (disturb && cyc == 4) begin
        start = 1'b1;
        num_trials = 8'd1;
        capture_delay = 4'd9;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_fail_count"}, 32'(fail_count), 32'(exp_fail));
    check({tag, "_path_input"}, 32'(path_input), 32'(exp_pi));
    check({tag, "_max_latency"}, 32'(max_latency), LAT_EN ? 32'(exp_lat) : 32'd0);
    if (disturb) start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_after"}, 32'(done), 32'd0);
    check({tag, "_fail_held"}, 32'(fail_count), 32'(exp_fail));
  endtask

  initial begin
    int saw_done;
    rst = 1'b1;
    start = 1'b0;
    num_trials = '0;
    capture_delay = '0;
    idle(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_path_input", 32'(path_input), 32'd0);
    check("rst_fail_count", 32'(fail_count), 32'd0);
    check("rst_max_latency", 32'(max_latency), 32'd0);
    rst = 1'b0;

    // zero trials: DONE two cycles after the start cycle, path untouched
    run_meas("zero_trials", 1, 0, 3, 0, 1, 0, 0, 1'b0);
    run_meas("k1_n4_d3", 1, 4, 3, 0, 20, 0, 2, 1'b0);
    run_meas("k6_n3_d2", 6, 3, 2, 3, 12, 1, 3, 1'b0);
    run_meas("k1_n2_d0", 1, 2, 0, 0, 6, 1, 2, 1'b0);

    // reset during WAIT of trial 2, with one failure already recorded
    k = 6;
    idle(10);
    num_trials = 8'd4;
    capture_delay = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    idle(6);
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_fail_count", 32'(fail_count), 32'd1);
    check("mid_path_input", 32'(path_input), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_path_input", 32'(path_input), 32'd0);
    check("rst_mid_fail_count", 32'(fail_count), 32'd0);
    saw_done = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) saw_done = 1;
      tick();
    end
    check("rst_mid_no_done", 32'(saw_done), 32'd0);

    run_meas("restart_disturbed", 1, 3, 2, 0, 12, 1, 2, 1'b1);
    run_meas("k1_n4_d3_again", 1, 4, 3, 0, 20, 1, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/path_delay_meter.md
PATH_DELAY_METER -- requirements
Module: path_delay_meter

Interface
REQ-001 Parameter: TRIAL_W, default 8, width of trial count and fail count.
REQ-002 Parameter: DLY_W, default 4, width of capture_delay and latency outputs.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  one-cycle request to run a measurement; ignored unless busy=0.
REQ-006 Port: num_trials  input  TRIAL_W  number of launch/capture trials, sampled when start is accepted.
REQ-007 Port: capture_delay  input  DLY_W  cycles from launch to capture, sampled when start is accepted; 0 treated as 1.
REQ-008 Port: path_input  output  1  launch level driven into the delay path under test.
REQ-009 Port: path_result  input  1  delay path output, registered internally into res_q every cycle.
REQ-010 Port: busy  output  1  high from the cycle after start acceptance until done.
REQ-011 Port: done  output  1  one-cycle pulse when the run completes.
REQ-012 Port: fail_count  output  TRIAL_W  trials whose captured value mismatched; valid while done=1 and held until next start.
REQ-013 Port: max_latency  output  DLY_W  worst observed arrival latency in cycles (see Configuration).

Function
REQ-014 FSM states: IDLE, LAUNCH, WAIT, CAPTURE, DONE.
REQ-015 IDLE: on start with busy=0, latch num_trials/capture_delay, clear fail_count, max_latency and trial counter, go LAUNCH; if latched num_trials=0, go DONE.
REQ-016 LAUNCH (1 cycle): invert path_input, load wait counter with max(capture_delay,1), go WAIT.
REQ-017 WAIT: decrement wait counter each cycle; go CAPTURE in the cycle the counter reaches 0.
REQ-018 CAPTURE (1 cycle): compare res_q with path_input; mismatch increments fail_count, saturating at all-ones; increment trial counter.
REQ-019 CAPTURE exit: trial counter equals latched num_trials -> DONE, else LAUNCH.
REQ-020 DONE (1 cycle): done=1, busy=0 on the next cycle, go IDLE.
REQ-021 Consecutive trials alternate transition direction (rise, fall, rise, ...), since path_input is never restored between trials.
REQ-022 start while busy=1, or while in DONE, has no effect.
REQ-023 Changes to num_trials/capture_delay during a run have no effect.
REQ-024 Trial period = capture_delay(eff) + 2 cycles; total run = num_trials*(capture_delay(eff)+2) cycles from LAUNCH entry to DONE.

Reset
REQ-025 rst=1 at a clock edge forces IDLE from any state, including mid-run, with no done pulse.
REQ-026 Reset values: path_input=0, res_q=0, busy=0, done=0, fail_count=0, max_latency=0, all internal counters 0.

Configuration
REQ-027 Macro PDM_LATENCY_EN, when defined: in WAIT, a per-trial cycle counter starts at 1 on the first WAIT cycle, and the first cycle res_q equals path_input records that count; max_latency takes the maximum recorded count over the run.
REQ-028 With PDM_LATENCY_EN: a trial with no arrival before CAPTURE records capture_delay(eff)+1, saturating at all-ones.
REQ-029 Without PDM_LATENCY_EN: max_latency is tied to 0 and no latency logic is built; all other behaviour is unchanged.

Verification (bench models the path as a k-cycle shift register from path_input to path_result)
REQ-030 k=1, num_trials=4, capture_delay=3 -> done after 20 cycles, fail_count=0, path_input ends at 0; with PDM_LATENCY_EN, max_latency=2.
REQ-031 k=6, num_trials=3, capture_delay=2 -> fail_count=3.
REQ-032 num_trials=0 -> done pulses 2 cycles after start, fail_count=0, path_input unchanged.
REQ-033 rst asserted in WAIT of trial 2 -> next cycle busy=0, path_input=0, fail_count=0, no done pulse; a subsequent start runs normally.
REQ-034 capture_delay=0, k=1, num_trials=2 -> behaves as capture_delay=1, run takes 6 cycles, fail_count=0.
REQ-035 start re-pulsed mid-run -> ignored; fail_count and cycle count match an undisturbed run.
